multicycle_controller: RTL and testbench

Main control FSM that sequences a shared multi-cycle RV32I-subset datapath with one ALU and one unified instruction/data memory port. It issues per-state enables and mux selects for PC, IR, register file, ALU and memory, and stalls on a memory ready handshake. The block sits beside the datapath registers (PC, IR, OldPC, Data, ALUOut) in the multi-cycle top and replaces the combinational Control_Unit.

---
 rtl/multicycle_controller.sv | 224 ++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Main control FSM for a shared multi-cycle RV32I-subset datapath: one ALU and
// one unified instruction/data memory port. It sequences each instruction
// through fetch, decode and execute phases and stalls on the memory handshake.
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   op, funct3,      instruction fields instr[6:0], instr[14:12] and instr[30]
//   funct7b5
//   zero             ALU Zero flag, used by the beq branch decision
//   mem_ready        memory completes the current access this cycle
//   mem_req, AdrSrc, memory request, address select (PC/ALUOut), write strobe
//   MemWrite
//   IRWrite, PCWrite register load enables for IR/OldPC and PC
//   RegWrite         register file write enable
//   ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc   datapath mux selects
//   retire           single-cycle pulse when an instruction completes
//   illegal          high while the FSM is parked in TRAP
module multicycle_controller #(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       retire,
  output logic       illegal
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [2:0] funct_ctrl;
  logic [1:0] imm_src;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= next_state;
  end

  // Next-state logic; unused codes 12..15 fall back to FETCH.
  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:    next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_RTYPE:          next_state = S_EXECR;
          OP_ITYPE:          next_state = S_EXECI;
          OP_JAL:            next_state = S_JAL;
          OP_BEQ:            next_state = S_BEQ;
          default:           next_state = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
        endcase
      end
      S_MEMADR:   next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  next_state = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    next_state = S_FETCH;
      S_MEMWRITE: next_state = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:    next_state = S_ALUWB;
      S_EXECI:    next_state = S_ALUWB;
      S_ALUWB:    next_state = S_FETCH;
      S_JAL:      next_state = S_ALUWB;
      S_BEQ:      next_state = S_FETCH;
      S_TRAP:     next_state = S_TRAP;
      default:    next_state = S_FETCH;
    endcase
  end

  // ALU operation for R/I-type execute; sub only for R-type (op[5]) with funct7b5.
  always_comb begin
    funct_ctrl = ALU_ADD;
    case (funct3)
      3'b000:  funct_ctrl = (op[5] && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  funct_ctrl = ALU_SLT;
      3'b110:  funct_ctrl = ALU_OR;
      3'b111:  funct_ctrl = ALU_AND;
      default: funct_ctrl = ALU_ADD;
    endcase
  end

  // Immediate format, decoded from op independently of state.
  always_comb begin
    imm_src = 2'b00;
    case (op)
      OP_STORE: imm_src = 2'b01;
      OP_BEQ:   imm_src = 2'b10;
      OP_JAL:   imm_src = 2'b11;
      default:  imm_src = 2'b00;
    endcase
  end

  // Output decode; everything is held at zero while rst is asserted.
  always_comb begin
    mem_req    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RD2;
    ALUControl = ALU_ADD;
    ImmSrc     = 2'b00;
    retire     = 1'b0;
    illegal    = 1'b0;
    if (!rst) begin
      ImmSrc = imm_src;
      case (state)
        S_FETCH: begin
          mem_req   = 1'b1;
          ALUSrcB   = SRCB_FOUR;
          ResultSrc = RES_ALURES;
          IRWrite   = mem_ready;
          PCWrite   = mem_ready;
        end
        S_DECODE: begin
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_IMM;
        end
        S_MEMADR: begin
          ALUSrcA = SRCA_RD1;
          ALUSrcB = SRCB_IMM;
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          AdrSrc  = 1'b1;
        end
        S_MEMWB: begin
          ResultSrc = RES_DATA;
          RegWrite  = 1'b1;
          retire    = 1'b1;
        end
        S_MEMWRITE: begin
          mem_req  = 1'b1;
          AdrSrc   = 1'b1;
          MemWrite = 1'b1;
          retire   = mem_ready;
        end
        S_EXECR: begin
          ALUSrcA    = SRCA_RD1;
          ALUSrcB    = SRCB_RD2;
          ALUControl = funct_ctrl;
        end
        S_EXECI: begin
          ALUSrcA    = SRCA_RD1;
          ALUSrcB    = SRCB_IMM;
          ALUControl = funct_ctrl;
        end
        S_ALUWB: begin
          RegWrite = 1'b1;
          retire   = 1'b1;
        end
        S_JAL: begin
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_FOUR;
          PCWrite = 1'b1;
        end
        S_BEQ: begin
          ALUSrcA    = SRCA_RD1;
          ALUSrcB    = SRCB_RD2;
          ALUControl = ALU_SUB;
          PCWrite    = zero;
          retire     = 1'b1;
        end
        S_TRAP:  illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. Two instances run in lockstep:
// u_trap (TRAP_ON_ILLEGAL=1) and u_nop (TRAP_ON_ILLEGAL=0). The reference model
// expands each instruction into its expected per-cycle phase sequence, including
// memory wait cycles, and derives the expected control word for every cycle.
module tb_multicycle_controller;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  typedef struct packed {
    logic        rst;
    logic        mr;
    logic        zero;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [3:0]  st1;
    logic [18:0] o1;
    logic [3:0]  st0;
    logic [18:0] o0;
    logic        chk_st;
  } cyc_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic mem_req_t, AdrSrc_t, MemWrite_t, IRWrite_t, PCWrite_t, RegWrite_t, retire_t, illegal_t;
  logic [1:0] ResultSrc_t, ALUSrcA_t, ALUSrcB_t, ImmSrc_t;
  logic [2:0] ALUControl_t;
  logic mem_req_n, AdrSrc_n, MemWrite_n, IRWrite_n, PCWrite_n, RegWrite_n, retire_n, illegal_n;
  logic [1:0] ResultSrc_n, ALUSrcA_n, ALUSrcB_n, ImmSrc_n;
  logic [2:0] ALUControl_n;

  int errors = 0;
  int checks = 0;

  cyc_t       q[$];
  logic       trapped1 = 1'b0;
  logic [6:0] cur_op = 7'd0;
  logic [2:0] cur_f3 = 3'd0;
  logic       cur_f7 = 1'b0;

  always #5 clk = ~clk;

  multicycle_controller #(.TRAP_ON_ILLEGAL(1'b1)) u_trap (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req_t), .AdrSrc(AdrSrc_t),
    .MemWrite(MemWrite_t), .IRWrite(IRWrite_t), .PCWrite(PCWrite_t),
    .RegWrite(RegWrite_t), .ResultSrc(ResultSrc_t), .ALUSrcA(ALUSrcA_t),
    .ALUSrcB(ALUSrcB_t), .ALUControl(ALUControl_t), .ImmSrc(ImmSrc_t),
    .retire(retire_t), .illegal(illegal_t)
  );

  multicycle_controller #(.TRAP_ON_ILLEGAL(1'b0)) u_nop (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req_n), .AdrSrc(AdrSrc_n),
    .MemWrite(MemWrite_n), .IRWrite(IRWrite_n), .PCWrite(PCWrite_n),
    .RegWrite(RegWrite_n), .ResultSrc(ResultSrc_n), .ALUSrcA(ALUSrcA_n),
    .ALUSrcB(ALUSrcB_n), .ALUControl(ALUControl_n), .ImmSrc(ImmSrc_n),
    .retire(retire_n), .illegal(illegal_n)
  );

  logic [18:0] obs_t, obs_n;
  logic [3:0]  st_t, st_n;
  assign obs_t = {mem_req_t, AdrSrc_t, MemWrite_t, IRWrite_t, PCWrite_t, RegWrite_t,
                  ResultSrc_t, ALUSrcA_t, ALUSrcB_t, ALUControl_t, ImmSrc_t, retire_t, illegal_t};
  assign obs_n = {mem_req_n, AdrSrc_n, MemWrite_n, IRWrite_n, PCWrite_n, RegWrite_n,
                  ResultSrc_n, ALUSrcA_n, ALUSrcB_n, ALUControl_n, ImmSrc_n, retire_n, illegal_n};
  assign st_t = u_trap.state;
  assign st_n = u_nop.state;

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [2:0] alu_ref(input logic [6:0] o, input logic [2:0] f, input logic f7);
    if (f == 3'b000) return (o[5] && f7) ? 3'b001 : 3'b000;
    if (f == 3'b010) return 3'b101;
    if (f == 3'b110) return 3'b011;
    if (f == 3'b111) return 3'b010;
    return 3'b000;
  endfunction

  function automatic logic [1:0] imm_ref(input logic [6:0] o);
    if (o == OP_SW)  return 2'b01;
    if (o == OP_BEQ) return 2'b10;
    if (o == OP_JAL) return 2'b11;
    return 2'b00;
  endfunction

  // Expected control word for one cycle spent in phase st.
  function automatic logic [18:0] ref_outs(input logic [3:0] st, input logic [6:0] o,
                                           input logic [2:0] f, input logic f7,
                                           input logic mr, input logic z, input logic r);
    logic mreq, adr, mw, irw, pcw, rw, ret, ill;
    logic [1:0] rs, a, b, imm;
    logic [2:0] alu;
    {mreq, adr, mw, irw, pcw, rw, ret, ill} = 8'd0;
    {rs, a, b, imm} = 8'd0;
    alu = 3'd0;
    if (!r) begin
      imm = imm_ref(o);
      case (st)
        4'd0:  begin mreq = 1'b1; b = 2'b10; rs = 2'b10; irw = mr; pcw = mr; end
        4'd1:  begin a = 2'b01; b = 2'b01; end
        4'd2:  begin a = 2'b10; b = 2'b01; end
        4'd3:  begin mreq = 1'b1; adr = 1'b1; end
        4'd4:  begin rs = 2'b01; rw = 1'b1; ret = 1'b1; end
        4'd5:  begin mreq = 1'b1; adr = 1'b1; mw = 1'b1; ret = mr; end
        4'd6:  begin a = 2'b10; b = 2'b00; alu = alu_ref(o, f, f7); end
        4'd7:  begin rw = 1'b1; ret = 1'b1; end
        4'd8:  begin a = 2'b10; b = 2'b01; alu = alu_ref(o, f, f7); end
        4'd9:  begin a = 2'b01; b = 2'b10; pcw = 1'b1; end
        4'd10: begin a = 2'b10; alu = 3'b001; pcw = z; ret = 1'b1; end
        4'd11: ill = 1'b1;
        default: ;
      endcase
    end
    return {mreq, adr, mw, irw, pcw, rw, rs, a, b, alu, imm, ret, ill};
  endfunction

  // Append one expected cycle; once trapped, the trapping instance sits in TRAP.
  task automatic push(input logic [3:0] st, input logic r, input logic mr, input logic z);
    cyc_t c;
    logic [3:0] st1;
    st1 = trapped1 ? 4'd11 : st;
    c.rst = r; c.mr = mr; c.zero = z;
    c.op = cur_op; c.f3 = cur_f3; c.f7 = cur_f7;
    c.st0 = st; c.st1 = st1;
    c.o0 = ref_outs(st, cur_op, cur_f3, cur_f7, mr, z, r);
    c.o1 = ref_outs(st1, cur_op, cur_f3, cur_f7, mr, z, r);
    c.chk_st = !r;
    q.push_back(c);
    if (r) trapped1 = 1'b0;
  endtask

  task automatic add_reset();
    push(4'd0, 1'b1, rb(), rb());
  endtask

  // Expand one instruction into its phase sequence with wf fetch and wm memory waits.
  task automatic add_instr(input logic [6:0] o, input logic [2:0] f, input logic f7,
                           input int wf, input int wm, input logic z);
    cur_op = o; cur_f3 = f; cur_f7 = f7;
    for (int i = 0; i < wf; i++) push(4'd0, 1'b0, 1'b0, z);
    push(4'd0, 1'b0, 1'b1, z);
    push(4'd1, 1'b0, rb(), z);
    case (o)
      OP_LW: begin
        push(4'd2, 1'b0, rb(), z);
        for (int i = 0; i < wm; i++) push(4'd3, 1'b0, 1'b0, z);
        push(4'd3, 1'b0, 1'b1, z);
        push(4'd4, 1'b0, rb(), z);
      end
      OP_SW: begin
        push(4'd2, 1'b0, rb(), z);
        for (int i = 0; i < wm; i++) push(4'd5, 1'b0, 1'b0, z);
        push(4'd5, 1'b0, 1'b1, z);
      end
      OP_R:    begin push(4'd6, 1'b0, rb(), z); push(4'd7, 1'b0, rb(), z); end
      OP_I:    begin push(4'd8, 1'b0, rb(), z); push(4'd7, 1'b0, rb(), z); end
      OP_JAL:  begin push(4'd9, 1'b0, rb(), z); push(4'd7, 1'b0, rb(), z); end
      OP_BEQ:  push(4'd10, 1'b0, rb(), z);
      default: trapped1 = 1'b1;
    endcase
  endtask

  task automatic drive(input cyc_t c);
    @(negedge clk);
    rst = c.rst; mem_ready = c.mr; zero = c.zero;
    op = c.op; funct3 = c.f3; funct7b5 = c.f7;
    #1;
  endtask

  task automatic test_reset();
    add_reset(); add_reset();
    add_instr(OP_I, 3'b000, 1'b0, 2, 0, 1'b0);
    foreach (q[i]) begin
      drive(q[i]);
      checks += 2;
      if (obs_t !== q[i].o1 || (q[i].chk_st && st_t !== q[i].st1)) begin
        errors++;
        $display("FAIL reset trap cyc=%0d got st=%0d out=%h exp st=%0d out=%h", i, st_t, obs_t, q[i].st1, q[i].o1);
      end
      if (obs_n !== q[i].o0 || (q[i].chk_st && st_n !== q[i].st0)) begin
        errors++;
        $display("FAIL reset nop cyc=%0d got st=%0d out=%h exp st=%0d out=%h", i, st_n, obs_n, q[i].st0, q[i].o0);
      end
    end
    q.delete();
  endtask

  task automatic test_directed();
    add_instr(OP_LW, 3'b010, 1'b0, 0, 0, 1'b0);
    add_instr(OP_SW, 3'b010, 1'b0, 0, 2, 1'b0);
    add_instr(OP_BEQ, 3'b000, 1'b0, 0, 0, 1'b1);
    add_instr(OP_BEQ, 3'b000, 1'b0, 0, 0, 1'b0);
    add_instr(OP_R, 3'b000, 1'b1, 0, 0, 1'b0);
    add_instr(OP_I, 3'b000, 1'b1, 0, 0, 1'b0);
    add_instr(OP_R, 3'b110, 1'b0, 1, 0, 1'b0);
    add_instr(OP_R, 3'b010, 1'b0, 0, 0, 1'b0);
    add_instr(OP_JAL, 3'b000, 1'b0, 0, 0, 1'b1);
    add_instr(OP_LW, 3'b000, 1'b0, 1, 3, 1'b1);
    foreach (q[i]) begin
      drive(q[i]);
      checks += 2;
      if (obs_t !== q[i].o1 || (q[i].chk_st && st_t !== q[i].st1)) begin
        errors++;
        $display("FAIL directed trap cyc=%0d got st=%0d out=%h exp st=%0d out=%h", i, st_t, obs_t, q[i].st1, q[i].o1);
      end
      if (obs_n !== q[i].o0 || (q[i].chk_st && st_n !== q[i].st0)) begin
        errors++;
        $display("FAIL directed nop cyc=%0d got st=%0d out=%h exp st=%0d out=%h", i, st_n, obs_n, q[i].st0, q[i].o0);
      end
    end
    q.delete();
  endtask

  task automatic test_illegal();
    add_reset();
    add_instr(OP_BAD, 3'b000, 1'b0, 0, 0, 1'b0);
    for (int k = 0; k < 5; k++) add_instr(OP_I, 3'(k), rb(), 0, 0, rb());
    add_reset();
    add_instr(OP_LW, 3'b010, 1'b0, 0, 1, 1'b0);
    foreach (q[i]) begin
      drive(q[i]);
      checks += 2;
      if (obs_t !== q[i].o1 || (q[i].chk_st && st_t !== q[i].st1)) begin
        errors++;
        $display("FAIL illegal trap cyc=%0d got st=%0d out=%h exp st=%0d out=%h", i, st_t, obs_t, q[i].st1, q[i].o1);
      end
      if (obs_n !== q[i].o0 || (q[i].chk_st && st_n !== q[i].st0)) begin
        errors++;
        $display("FAIL illegal nop cyc=%0d got st=%0d out=%h exp st=%0d out=%h", i, st_n, obs_n, q[i].st0, q[i].o0);
      end
    end
    q.delete();
  endtask

  task automatic test_reset_mid_write();
    cur_op = OP_SW; cur_f3 = 3'b010; cur_f7 = 1'b0;
    push(4'd0, 1'b0, 1'b1, 1'b0);
    push(4'd1, 1'b0, 1'b1, 1'b0);
    push(4'd2, 1'b0, 1'b1, 1'b0);
    push(4'd5, 1'b0, 1'b0, 1'b0);
    push(4'd5, 1'b0, 1'b0, 1'b0);
    push(4'd0, 1'b1, 1'b0, 1'b0);
    add_instr(OP_BEQ, 3'b000, 1'b0, 0, 0, 1'b1);
    foreach (q[i]) begin
      drive(q[i]);
      checks += 2;
      if (obs_t !== q[i].o1 || (q[i].chk_st && st_t !== q[i].st1)) begin
        errors++;
        $display("FAIL midwrite trap cyc=%0d got st=%0d out=%h exp st=%0d out=%h", i, st_t, obs_t, q[i].st1, q[i].o1);
      end
      if (obs_n !== q[i].o0 || (q[i].chk_st && st_n !== q[i].st0)) begin
        errors++;
        $display("FAIL midwrite nop cyc=%0d got st=%0d out=%h exp st=%0d out=%h", i, st_n, obs_n, q[i].st0, q[i].o0);
      end
    end
    q.delete();
  endtask

  task automatic test_random();
    logic [6:0] ops [6];
    ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ};
    for (int k = 0; k < 60; k++) begin
      add_instr(ops[$urandom_range(0, 5)], 3'($urandom_range(0, 7)), rb(),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), rb());
    end
    foreach (q[i]) begin
      drive(q[i]);
      checks += 2;
      if (obs_t !== q[i].o1 || (q[i].chk_st && st_t !== q[i].st1)) begin
        errors++;
        $display("FAIL random trap cyc=%0d got st=%0d out=%h exp st=%0d out=%h", i, st_t, obs_t, q[i].st1, q[i].o1);
      end
      if (obs_n !== q[i].o0 || (q[i].chk_st && st_n !== q[i].st0)) begin
        errors++;
        $display("FAIL random nop cyc=%0d got st=%0d out=%h exp st=%0d out=%h", i, st_n, obs_n, q[i].st0, q[i].o0);
      end
    end
    q.delete();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_illegal();
    test_reset_mid_write();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
